instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the multicycle RV32I core. Owns the program counter, the instruction register (IR) and the old-PC register. It runs an instruction-memory read over a valid/ready handshake when the control unit requests a fetch, and applies PC updates driven by the control unit's PCWrite/PCWriteCond/PCSource. It feeds `instruction` and `pc`/`old_pc` to the control unit, ALU operand muxes and immediate generator.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `NOP_INSTR`, 32'h0000_0013, IR value after reset (addi x0,x0,0)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, synchronous, active-high
- `fetch_req`  in  1  start a fetch (control unit S0: MemRead & IRWrite & !IorD)
- `PCWrite`  in  1  unconditional PC write
- `PCWriteCond`  in  1  PC write if `branch_taken`
- `branch_taken`  in  1  branch comparison result from ALU
- `PCSource`  in  2  next-PC select
- `alu_result`  in  XLEN  combinational ALU output
- `alu_out`  in  XLEN  registered ALU output
- `mem_req`  out  1  instruction read request valid
- `mem_addr`  out  XLEN  read address
- `mem_ready`  in  1  memory accepts request
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data
- `instruction`  out  32  IR contents
- `pc`  out  XLEN  current PC
- `old_pc`  out  XLEN  PC of the instruction in IR
- `fetch_busy`  out  1  FSM not IDLE
- `fetch_done`  out  1  one-cycle pulse, IR updated this edge
- `misaligned`  out  1  one-cycle pulse, rejected PC write target

## Operation
- FSM: IDLE → REQ → WAIT → DONE → IDLE.
  - IDLE: `fetch_req`=1 → REQ. `fetch_addr` latches `pc` and `old_pc` latches `pc` on the same edge.
  - REQ: `mem_req`=1. `mem_addr`=`fetch_addr`, held stable. On `mem_ready`=1, go to WAIT. If `mem_rvalid` is also 1 in that cycle, go straight to DONE and capture data.
  - WAIT: on `mem_rvalid`=1, IR ← `mem_rdata`, then DONE.
  - DONE: `fetch_done`=1 for one cycle, then IDLE.
- `fetch_req` outside IDLE is ignored; it is not queued.
- PC update enable: `pc_we` = `PCWrite` | (`PCWriteCond` & `branch_taken`). Accepted in any FSM state, because the fetch address is already latched.
- Next-PC by `PCSource`:
  - 00 → `alu_result` (PC+4 in S0)
  - 01 → `alu_out` (branch target)
  - 10 → {`alu_result`[XLEN-1:1],1'b0} (JALR)
  - 11 → hold `pc`
- Selected target with bits[1:0]≠0 (after the JALR bit-0 clear): PC not written; `misaligned` pulses for one cycle.
- IR and `old_pc` change only as described above.

## Timing
- Reset values: `pc`=RESET_PC, `old_pc`=RESET_PC, `fetch_addr`=RESET_PC, `instruction`=NOP_INSTR, state=IDLE. `mem_req`, `fetch_busy`, `fetch_done` and `misaligned` are all 0.
- Reset mid-fetch: FSM returns to IDLE on the next edge and `mem_req` drops; the late `mem_rvalid` is discarded.
- Minimum latency (`mem_ready` and `mem_rvalid` both 1 in the first REQ cycle): `fetch_req` at cycle 0, `mem_req` at cycle 1, `fetch_done` at cycle 2, new IR visible at cycle 2.
- `mem_rvalid` while in IDLE or DONE: ignored.
- `pc` updates on the edge after `pc_we`. `misaligned` is asserted in the cycle after the offending request.
- `fetch_busy` = state≠IDLE, registered.

## Structure
- Shared package `core_pkg`:
  - `PCSource` encodings `PC_SRC_ALU`, `PC_SRC_ALUOUT`, `PC_SRC_JALR`, `PC_SRC_HOLD`
  - fetch FSM state enum
  - `NOP_INSTR`
- Single module, no sub-module.
- Next-PC mux inline.

## Test plan
- Reset, then `fetch_req` with memory returning 32'h00500093 with zero wait → `mem_addr`=0, `fetch_done` at cycle 2, `instruction`=32'h00500093, `old_pc`=0.
- `fetch_req` with `mem_ready` delayed 3 cycles and `mem_rvalid` delayed a further 2 → `mem_req` held high with a constant `mem_addr` through REQ; IR written once; `fetch_done` is a single-cycle pulse.
- `PCWrite`=1, `PCSource`=00, `alu_result`=4 in the same cycle as `fetch_req` → `pc`=4, `mem_addr`=0, `old_pc`=0.
- `PCWriteCond`=1, `PCSource`=01, `alu_out`=0x40: with `branch_taken`=0, `pc` unchanged; with `branch_taken`=1, `pc`=0x40.
- `PCWrite`=1, `PCSource`=10, `alu_result`=0x101 → `pc`=0x100. Then `alu_result`=0x102 → `pc` unchanged and `misaligned` pulses once.
- `rst` asserted while in WAIT, then `mem_rvalid` arrives → IR stays at 32'h00000013, `pc`=RESET_PC, no `fetch_done`.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the multicycle RV32I core.
//   pc_src_e       : PCSource encodings driven by the control unit
//   fetch_state_e  : instruction-fetch FSM states
//   NOP_INSTR      : canonical NOP (addi x0,x0,0) loaded into IR at reset
// ---------------------------------------------------------------------------
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,  // combinational ALU result (PC+4 in S0)
    PC_SRC_ALUOUT = 2'b01,  // registered ALU output (branch target)
    PC_SRC_JALR   = 2'b10,  // ALU result with bit 0 cleared
    PC_SRC_HOLD   = 2'b11   // keep current PC
  } pc_src_e;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_WAIT = 2'b10,
    FETCH_DONE = 2'b11
  } fetch_state_e;

endpackage : core_pkg

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read channel used by the fetch unit.
//   mem_req    : read request valid            (master -> slave)
//   mem_addr   : read address, stable while req (master -> slave)
//   mem_ready  : slave accepts the request      (slave -> master)
//   mem_rvalid : read data valid                (slave -> master)
//   mem_rdata  : read data                      (slave -> master)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the multicycle RV32I core. Owns PC, IR and old-PC.
// A fetch request from the control unit latches the PC as the fetch address
// and runs one read over the memory handshake; PC updates from the control
// unit are applied independently of the fetch FSM.
//
// Ports:
//   clk, rst      : core clock, synchronous active-high reset
//   fetch_req     : start a fetch (accepted only in IDLE)
//   PCWrite       : unconditional PC write
//   PCWriteCond   : PC write qualified by branch_taken
//   branch_taken  : ALU branch comparison result
//   PCSource      : next-PC select (see core_pkg::pc_src_e)
//   alu_result    : combinational ALU output
//   alu_out       : registered ALU output
//   mem           : instruction-memory read channel (master side)
//   instruction   : IR contents
//   pc            : current PC
//   old_pc        : PC of the instruction held in IR
//   fetch_busy    : FSM not IDLE (registered)
//   fetch_done    : one-cycle pulse, IR updated on the previous edge
//   misaligned    : one-cycle pulse, a PC write target was rejected
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic                PCWrite,
  input  logic                PCWriteCond,
  input  logic                branch_taken,
  input  logic [1:0]          PCSource,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     alu_out,
  instr_fetch_unit_if.master  mem,
  output logic [31:0]         instruction,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     old_pc,
  output logic                fetch_busy,
  output logic                fetch_done,
  output logic                misaligned
);

  import core_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_pc_q;
  logic [XLEN-1:0] fetch_addr_q;
  logic [31:0]     ir_q;
  logic            busy_q;
  logic            misaligned_q;

  logic [XLEN-1:0] pc_target;
  logic            pc_we;
  logic            target_misaligned;
  logic            fetch_start;
  logic            ir_load;

  // -------------------------------------------------------------------------
  // Next-PC selection
  // -------------------------------------------------------------------------
  assign pc_we = PCWrite | (PCWriteCond & branch_taken);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    pc_target = pc_q;
    case (pc_src_e'(PCSource))
      PC_SRC_ALU:    pc_target = alu_result;
      PC_SRC_ALUOUT: pc_target = alu_out;
      PC_SRC_JALR:   pc_target = {alu_result[XLEN-1:1], 1'b0};
      PC_SRC_HOLD:   pc_target = pc_q;
      default:       pc_target = pc_q;
    endcase
  end

  // Checked after the JALR bit-0 clear, so only bit 1 can trip on JALR.
  assign target_misaligned = (pc_target[1:0] != 2'b00);

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  assign fetch_start = (state_q == FETCH_IDLE) && fetch_req;

  // Data may arrive together with acceptance in the first REQ cycle; in that
  // case WAIT is skipped entirely.
  assign ir_load = ((state_q == FETCH_REQ)  && mem.mem_ready && mem.mem_rvalid) ||
                   ((state_q == FETCH_WAIT) && mem.mem_rvalid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: if (fetch_req)  state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (mem.mem_ready) state_d = mem.mem_rvalid ? FETCH_DONE : FETCH_WAIT;
      end
      FETCH_WAIT: if (mem.mem_rvalid) state_d = FETCH_DONE;
      FETCH_DONE: state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      ir_q         <= NOP_INSTR;
      busy_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != FETCH_IDLE);
      misaligned_q <= pc_we && target_misaligned;

      // A PC write in the same cycle as fetch_start lands in pc_q, while the
      // fetch address and old_pc capture the pre-write PC.
      if (pc_we && !target_misaligned) pc_q <= pc_target;

      if (fetch_start) begin
        fetch_addr_q <= pc_q;
        old_pc_q     <= pc_q;
      end

      if (ir_load) ir_q <= mem.mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem.mem_req  = (state_q == FETCH_REQ);
  assign mem.mem_addr = fetch_addr_q;

  assign instruction = ir_q;
  assign pc          = pc_q;
  assign old_pc      = old_pc_q;
  assign fetch_busy  = busy_q;
  assign fetch_done  = (state_q == FETCH_DONE);
  assign misaligned  = misaligned_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            fetch_req;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            branch_taken;
  logic [1:0]      PCSource;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] alu_out;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] old_pc;
  logic            fetch_busy;
  logic            fetch_done;
  logic            misaligned;

  int n_checks;
  int n_fail;

  instr_fetch_unit_if #(.XLEN(XLEN)) mem_bus ();

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .branch_taken(branch_taken),
    .PCSource    (PCSource),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .mem         (mem_bus),
    .instruction (instruction),
    .pc          (pc),
    .old_pc      (old_pc),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_req          = 1'b0;
    PCWrite            = 1'b0;
    PCWriteCond        = 1'b0;
    branch_taken       = 1'b0;
    PCSource           = 2'b00;
    alu_result         = '0;
    alu_out            = '0;
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
    end
    n_checks++;
    if (old_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_old_pc: got %h want %h", old_pc, 32'h0);
    end
    n_checks++;
    if (instruction !== NOP) begin
      n_fail++; $display("FAIL reset_ir: got %h want %h", instruction, NOP);
    end
    n_checks++;
    if ({mem_bus.mem_req, fetch_busy, fetch_done, misaligned} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: req/busy/done/mis got %b want 0000",
               {mem_bus.mem_req, fetch_busy, fetch_done, misaligned});
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_zero_wait();
    fetch_req = 1'b1;                       // cycle 0
    step();                                 // cycle 1: REQ
    fetch_req = 1'b0;
    n_checks++;
    if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL zw_req: req=%b addr=%h want req=1 addr=0",
               mem_bus.mem_req, mem_bus.mem_addr);
    end
    n_checks++;
    if ({fetch_busy, fetch_done} !== 2'b10) begin
      n_fail++; $display("FAIL zw_busy_c1: busy/done got %b want 10", {fetch_busy, fetch_done});
    end
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h0050_0093;
    step();                                 // cycle 2: DONE
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if (fetch_done !== 1'b1) begin
      n_fail++; $display("FAIL zw_done_c2: got %b want 1", fetch_done);
    end
    n_checks++;
    if (instruction !== 32'h0050_0093) begin
      n_fail++; $display("FAIL zw_ir: got %h want %h", instruction, 32'h0050_0093);
    end
    n_checks++;
    if (old_pc !== 32'h0) begin
      n_fail++; $display("FAIL zw_old_pc: got %h want %h", old_pc, 32'h0);
    end
    step();                                 // cycle 3: IDLE
    n_checks++;
    if ({fetch_busy, fetch_done, mem_bus.mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL zw_idle: busy/done/req got %b want 000",
               {fetch_busy, fetch_done, mem_bus.mem_req});
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wait_states();
    PCWrite    = 1'b1;
    PCSource   = 2'b00;
    alu_result = 32'h8;
    step();
    PCWrite    = 1'b0;
    n_checks++;
    if (pc !== 32'h8) begin
      n_fail++; $display("FAIL ws_pc_setup: got %h want %h", pc, 32'h8);
    end

    fetch_req = 1'b1;
    step();                                 // first REQ cycle
    fetch_req = 1'b0;
    // Move the PC while the request is outstanding; mem_addr must not follow.
    PCWrite    = 1'b1;
    alu_result = 32'hC;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 32'h8}) begin
        n_fail++;
        $display("FAIL ws_req_hold[%0d]: req=%b addr=%h want req=1 addr=8",
                 i, mem_bus.mem_req, mem_bus.mem_addr);
      end
      step();
      PCWrite = 1'b0;
    end
    mem_bus.mem_ready = 1'b1;               // accepted in 4th REQ cycle
    n_checks++;
    if ({mem_bus.mem_req, mem_bus.mem_addr, pc} !== {1'b1, 32'h8, 32'hC}) begin
      n_fail++;
      $display("FAIL ws_req_accept: req=%b addr=%h pc=%h want req=1 addr=8 pc=c",
               mem_bus.mem_req, mem_bus.mem_addr, pc);
    end
    step();                                 // WAIT 1
    mem_bus.mem_ready = 1'b0;
    fetch_req         = 1'b1;               // ignored outside IDLE
    n_checks++;
    if ({mem_bus.mem_req, fetch_busy, fetch_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL ws_wait1: req/busy/done got %b want 010",
               {mem_bus.mem_req, fetch_busy, fetch_done});
    end
    step();                                 // WAIT 2
    fetch_req = 1'b0;
    n_checks++;
    if (instruction !== 32'h0050_0093) begin
      n_fail++; $display("FAIL ws_ir_early: got %h want %h", instruction, 32'h0050_0093);
    end
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h00A0_0113;
    step();                                 // DONE
    mem_bus.mem_rdata  = 32'hDEAD_BEEF;     // rvalid in DONE is ignored
    n_checks++;
    if ({fetch_done, instruction, old_pc} !== {1'b1, 32'h00A0_0113, 32'h8}) begin
      n_fail++;
      $display("FAIL ws_done: done=%b ir=%h old_pc=%h want 1 00a00113 00000008",
               fetch_done, instruction, old_pc);
    end
    step();                                 // IDLE
    mem_bus.mem_rdata = 32'h1111_1111;      // rvalid in IDLE is ignored
    n_checks++;
    if ({fetch_done, fetch_busy, instruction} !== {2'b00, 32'h00A0_0113}) begin
      n_fail++;
      $display("FAIL ws_single_pulse: done=%b busy=%b ir=%h want 0 0 00a00113",
               fetch_done, fetch_busy, instruction);
    end
    step();
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if ({fetch_busy, instruction} !== {1'b0, 32'h00A0_0113}) begin
      n_fail++;
      $display("FAIL ws_no_queue: busy=%b ir=%h want 0 00a00113", fetch_busy, instruction);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_pc_write_during_fetch();
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch_req  = 1'b1;
    PCWrite    = 1'b1;
    PCSource   = 2'b00;
    alu_result = 32'h4;
    step();
    fetch_req  = 1'b0;
    PCWrite    = 1'b0;
    n_checks++;
    if ({pc, mem_bus.mem_addr, old_pc} !== {32'h4, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL pcw_fetch: pc=%h addr=%h old_pc=%h want 4 0 0",
               pc, mem_bus.mem_addr, old_pc);
    end
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h0040_0193;
    step();
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if ({fetch_done, instruction, old_pc, pc} !== {1'b1, 32'h0040_0193, 32'h0, 32'h4}) begin
      n_fail++;
      $display("FAIL pcw_done: done=%b ir=%h old_pc=%h pc=%h want 1 00400193 0 4",
               fetch_done, instruction, old_pc, pc);
    end
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_branch();
    PCWriteCond  = 1'b1;
    PCSource     = 2'b01;
    alu_out      = 32'h40;
    branch_taken = 1'b0;
    step();
    n_checks++;
    if ({pc, misaligned} !== {32'h4, 1'b0}) begin
      n_fail++; $display("FAIL br_not_taken: pc=%h mis=%b want 4 0", pc, misaligned);
    end
    branch_taken = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'h40) begin
      n_fail++; $display("FAIL br_taken: got %h want %h", pc, 32'h40);
    end
    PCWriteCond = 1'b0;
    alu_out     = 32'h80;                   // taken but no write enable
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (pc !== 32'h40) begin
      n_fail++; $display("FAIL br_no_enable: got %h want %h", pc, 32'h40);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_jalr_misaligned();
    PCWrite    = 1'b1;
    PCSource   = 2'b10;
    alu_result = 32'h101;
    step();
    n_checks++;
    if ({pc, misaligned} !== {32'h100, 1'b0}) begin
      n_fail++; $display("FAIL jalr_clear: pc=%h mis=%b want 100 0", pc, misaligned);
    end
    alu_result = 32'h102;
    step();
    PCWrite = 1'b0;
    n_checks++;
    if ({pc, misaligned} !== {32'h100, 1'b1}) begin
      n_fail++; $display("FAIL jalr_misaligned: pc=%h mis=%b want 100 1", pc, misaligned);
    end
    step();
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++; $display("FAIL mis_single_pulse: got %b want 0", misaligned);
    end
    PCWrite    = 1'b1;
    PCSource   = 2'b00;
    alu_result = 32'h42;                    // bit 1 set on the plain ALU path
    step();
    n_checks++;
    if ({pc, misaligned} !== {32'h100, 1'b1}) begin
      n_fail++; $display("FAIL alu_misaligned: pc=%h mis=%b want 100 1", pc, misaligned);
    end
    PCSource = 2'b11;                       // hold
    step();
    PCWrite = 1'b0;
    n_checks++;
    if ({pc, misaligned} !== {32'h100, 1'b0}) begin
      n_fail++; $display("FAIL pc_hold: pc=%h mis=%b want 100 0", pc, misaligned);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_fetch();
    fetch_req = 1'b1;
    step();                                 // REQ
    fetch_req         = 1'b0;
    mem_bus.mem_ready = 1'b1;
    step();                                 // WAIT
    mem_bus.mem_ready = 1'b0;
    n_checks++;
    if ({fetch_busy, mem_bus.mem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL rmf_in_wait: busy/req got %b want 10", {fetch_busy, mem_bus.mem_req});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({fetch_busy, mem_bus.mem_req, pc, old_pc, instruction} !==
        {2'b00, 32'h0, 32'h0, NOP}) begin
      n_fail++;
      $display("FAIL rmf_after_rst: busy=%b req=%b pc=%h old_pc=%h ir=%h want 0 0 0 0 %h",
               fetch_busy, mem_bus.mem_req, pc, old_pc, instruction, NOP);
    end
    mem_bus.mem_rvalid = 1'b1;              // late response
    mem_bus.mem_rdata  = 32'hAAAA_AAAA;
    step();
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if ({fetch_done, fetch_busy, instruction} !== {2'b00, NOP}) begin
      n_fail++;
      $display("FAIL rmf_late_rvalid: done=%b busy=%b ir=%h want 0 0 %h",
               fetch_done, fetch_busy, instruction, NOP);
    end
    step();
    n_checks++;
    if ({fetch_done, instruction} !== {1'b0, NOP}) begin
      n_fail++;
      $display("FAIL rmf_no_done: done=%b ir=%h want 0 %h", fetch_done, instruction, NOP);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();

    test_reset();
    test_zero_wait();
    test_wait_states();
    clear_inputs();
    test_pc_write_during_fetch();
    clear_inputs();
    test_branch();
    clear_inputs();
    test_jalr_misaligned();
    clear_inputs();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch_unit
